spi_master_2cs: RTL and testbench
=================================

// Module: spi_master_2cs
// PURPOSE
//  SPI mode-0 master (CPOL=0, CPHA=0, MSB first, 8-bit frames) driving two slaves via active-low cs1/cs2.
//  Runs back-to-back frames with no start strobe; can_write marks the point where the next byte is taken.
//  Sits between a byte producer and two spi_slave-style peripherals sharing sclk, mosi and miso.
// PARAMETERS
//  SCLK_HALF  1  clk cycles per sclk half-period (>=1); sclk = clk/(2*SCLK_HALF)
// PORTS
//  clk                   in   1  system clock; all logic on posedge
//  rst_n                 in   1  asynchronous, active-low reset
//  miso                  in   1  shared slave->master data; only the selected slave drives it, others hi-Z
//  data                  in   8  byte to send; sampled in LOAD
//  slave_num             in   1  0 selects cs1, 1 selects cs2; sampled in LOAD
//  can_write             out  1  high for exactly one clk (IDLE); producer updates data on its rising edge
//  slave_data_on_master  out  8  last byte received from miso; holds until the next frame completes
//  sclk                  out  1  serial clock, idle low
//  mosi                  out  1  master->slave data
//  cs1                   out  1  slave 0 select, active low
//  cs2                   out  1  slave 1 select, active low
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE-pending, sclk=0, mosi=0, cs1=cs2=1, can_write=0, slave_data_on_master=0,
//   shift registers=0, bit counter=0. First posedge after release enters IDLE.
//  FSM: IDLE -> LOAD -> SHIFT_HI/SHIFT_LO x8 -> DONE -> IDLE (repeats forever).
//  IDLE (1 clk): can_write=1, cs both high, sclk=0.
//  LOAD (SCLK_HALF clk): can_write=0; latch tx=data and sel=slave_num; drive selected cs low, mosi=tx[7].
//   The unselected cs stays high for the whole frame.
//  SHIFT_HI (SCLK_HALF clk): sclk=1; on the last clk of the phase, rx <= {rx[6:0], miso}.
//  SHIFT_LO (SCLK_HALF clk): sclk=0; mosi moves to the next lower bit of tx.
//   After the 8th low phase, go to DONE.
//  DONE (1 clk): cs deasserted (both high), slave_data_on_master <= rx, mosi=0, next state IDLE.
//  Frame length = 2 + 17*SCLK_HALF clk (19 clk at SCLK_HALF=1).
//   cs low for 17*SCLK_HALF clk; exactly 8 sclk rising edges per frame.
//  mosi is stable across each sclk rising edge.
//  miso is sampled before the falling edge on which the slave shifts.
//  data/slave_num changes outside LOAD have no effect on the current frame.
//  X/Z on miso is shifted in as-is; no filtering is done.
//  Reset mid-frame aborts immediately: cs high, sclk low, slave_data_on_master cleared to 0, no can_write pulse.
//  Slave contract: shift mosi in on sclk rise, drive miso MSB-first, update miso on sclk fall,
//   hi-Z miso while its cs is high.
// TESTING
//  1. Reset release, slave 0 preloaded 0xA5, data=0x03, slave_num=0 -> cs1 low 17 clk, cs2 stays 1,
//     slave 0 receives 0x03, slave_data_on_master=0xA5 in DONE, can_write pulse 1 clk later.
//  2. Free-run with producer doing data+=3 on posedge can_write -> consecutive frames carry 0x00,0x03,0x06,0x09,
//     period 19 clk, exactly 8 sclk rises per frame.
//  3. slave_num=1, slave 1 preloaded 0x3C, data=0xFF -> only cs2 toggles; slave 1 receives 0xFF;
//     slave_data_on_master=0x3C; slave 0 register unchanged.
//  4. Toggle slave_num mid-frame -> current frame keeps the old cs; the change applies at the next LOAD.
//  5. Pull rst_n low at sclk edge 4 -> cs1=cs2=1, sclk=0, slave_data_on_master=0 immediately;
//     a clean frame follows release.
//  6. SCLK_HALF=3, data=0x81 -> sclk period 6 clk, frame 53 clk, mosi pattern 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/spi_master_2cs.sv
// spi_master_2cs: free-running SPI mode-0 master, 8-bit MSB-first frames,
// with two active-low chip selects chosen per frame by slave_num.
module spi_master_2cs #(
  parameter int SCLK_HALF = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       miso,
  input  logic [7:0] data,
  input  logic       slave_num,
  output logic       can_write,
  output logic [7:0] slave_data_on_master,
  output logic       sclk,
  output logic       mosi,
  output logic       cs1,
  output logic       cs2
);

  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    ST_WAKE = 3'd0,
    ST_IDLE = 3'd1,
    ST_LOAD = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t           state_r;
  logic [6:0]       tx_r;
  logic [7:0]       rx_r;
  logic [2:0]       bit_cnt_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             phase_end_s;

  assign phase_end_s = (div_cnt_r == DIV_LAST);

  // Frame sequencer; every output is set on entry to the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r              <= ST_WAKE;
      tx_r                 <= 7'd0;
      rx_r                 <= 8'd0;
      bit_cnt_r            <= 3'd0;
      div_cnt_r            <= '0;
      can_write            <= 1'b0;
      slave_data_on_master <= 8'd0;
      sclk                 <= 1'b0;
      mosi                 <= 1'b0;
      cs1                  <= 1'b1;
      cs2                  <= 1'b1;
    end else begin
      case (state_r)
        ST_WAKE: begin
          state_r   <= ST_IDLE;
          can_write <= 1'b1;
          cs1       <= 1'b1;
          cs2       <= 1'b1;
          sclk      <= 1'b0;
          mosi      <= 1'b0;
        end
        ST_IDLE: begin
          // tx_r keeps only the bits still to be sent; bit 7 goes straight out
          state_r   <= ST_LOAD;
          can_write <= 1'b0;
          tx_r      <= data[6:0];
          mosi      <= data[7];
          cs1       <= slave_num;
          cs2       <= ~slave_num;
          div_cnt_r <= '0;
          bit_cnt_r <= 3'd0;
        end
        ST_LOAD: begin
          if (phase_end_s) begin
            state_r   <= ST_HI;
            sclk      <= 1'b1;
            div_cnt_r <= '0;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end
        ST_HI: begin
          if (phase_end_s) begin
            // miso sampled just before the falling edge the slave shifts on
            state_r   <= ST_LO;
            sclk      <= 1'b0;
            rx_r      <= {rx_r[6:0], miso};
            mosi      <= tx_r[6];
            tx_r      <= {tx_r[5:0], 1'b0};
            div_cnt_r <= '0;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end
        ST_LO: begin
          if (phase_end_s) begin
            div_cnt_r <= '0;
            if (bit_cnt_r == 3'd7) begin
              state_r              <= ST_DONE;
              cs1                  <= 1'b1;
              cs2                  <= 1'b1;
              mosi                 <= 1'b0;
              slave_data_on_master <= rx_r;
            end else begin
              state_r   <= ST_HI;
              sclk      <= 1'b1;
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          can_write <= 1'b1;
        end
        default: begin
          state_r   <= ST_WAKE;
          can_write <= 1'b0;
          sclk      <= 1'b0;
          mosi      <= 1'b0;
          cs1       <= 1'b1;
          cs2       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_2cs.sv
// Directed bench for spi_master_2cs: two slave models on the SCLK_HALF=1 instance
// plus a SCLK_HALF=3 instance, checked against a queue of expected frames.
module tb_spi_master_2cs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       slave_num;

  logic       can_write, sclk, mosi, cs1, cs2;
  logic [7:0] sdom;
  wire        miso;

  logic       can_write3, sclk3, mosi3, cs1_3, cs2_3;
  logic [7:0] sdom3;
  logic       miso3;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] tx;
    logic       sel;
    logic [7:0] rx;
  } exp_t;
  exp_t sb[$];

  logic [7:0] s_pre [2];
  logic [7:0] s_reg [2] = '{8'h00, 8'h00};
  logic       s_bit [2];
  logic [7:0] exp_sreg [2] = '{8'h00, 8'h00};
  logic       cs1_q = 1'b1, cs2_q = 1'b1, sclk_q = 1'b0;
  int         rises, c1_low, c2_low;
  logic [7:0] mbits;

  always #5 clk = ~clk;

  spi_master_2cs #(.SCLK_HALF(1)) dut (
    .clk(clk), .rst_n(rst_n), .miso(miso), .data(data), .slave_num(slave_num),
    .can_write(can_write), .slave_data_on_master(sdom), .sclk(sclk), .mosi(mosi),
    .cs1(cs1), .cs2(cs2)
  );

  spi_master_2cs #(.SCLK_HALF(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .miso(miso3), .data(data), .slave_num(slave_num),
    .can_write(can_write3), .slave_data_on_master(sdom3), .sclk(sclk3), .mosi(mosi3),
    .cs1(cs1_3), .cs2(cs2_3)
  );

  assign miso = !cs1 ? s_reg[0][7] : (!cs2 ? s_reg[1][7] : 1'bz);

  // Mode-0 slaves (preload on cs fall, capture on sclk rise, shift on fall) and frame monitor.
  always @(negedge clk) begin
    if (!cs1 && cs1_q)                s_reg[0] <= s_pre[0];
    else if (!cs1 && sclk && !sclk_q) s_bit[0] <= mosi;
    else if (!cs1 && !sclk && sclk_q) s_reg[0] <= {s_reg[0][6:0], s_bit[0]};
    if (!cs2 && cs2_q)                s_reg[1] <= s_pre[1];
    else if (!cs2 && sclk && !sclk_q) s_bit[1] <= mosi;
    else if (!cs2 && !sclk && sclk_q) s_reg[1] <= {s_reg[1][6:0], s_bit[1]};
    if (can_write) begin
      rises <= 0; c1_low <= 0; c2_low <= 0; mbits <= 8'h00;
    end else begin
      if (!cs1) c1_low <= c1_low + 1;
      if (!cs2) c2_low <= c2_low + 1;
      if (sclk && !sclk_q) begin
        rises <= rises + 1;
        mbits <= {mbits[6:0], mosi};
      end
    end
    cs1_q  <= cs1;
    cs2_q  <= cs2;
    sclk_q <= sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cw();
    int n = 0;
    while (!can_write && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_can_write", can_write, 1);
  endtask

  // Called at the negedge inside IDLE; returns at the negedge inside the next IDLE.
  task automatic run_frame(input logic [7:0] tx, input logic sel, input logic [7:0] pre, input bit mid);
    int   n = 0;
    bit   seen = 0, done = 0;
    exp_t e;
    data = tx;
    slave_num = sel;
    s_pre[sel] = pre;
    sb.push_back('{tx: tx, sel: sel, rx: pre});
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (mid && n == 8) begin
        slave_num = ~sel;
        data = ~tx;
      end
      if (!cs1 || !cs2) seen = 1;
      else if (seen) done = 1;
    end
    chk("frame_done", done, 1);
    e = sb.pop_front();
    chk("frame_len", n + 1, 19);
    chk("rx_byte", sdom, e.rx);
    chk("slave_rx", s_reg[e.sel], e.tx);
    chk("other_slave", s_reg[~e.sel], exp_sreg[~e.sel]);
    chk("sclk_rises", rises, 8);
    chk("mosi_bits", mbits, e.tx);
    chk("cs_sel_low", e.sel ? c2_low : c1_low, 17);
    chk("cs_other_low", e.sel ? c1_low : c2_low, 0);
    chk("cw_in_done", can_write, 0);
    @(negedge clk);
    chk("cw_pulse", can_write, 1);
    exp_sreg[e.sel] = e.tx;
  endtask

  initial begin
    int   n, r, t1, t2;
    bit   seen, done;
    logic p;
    logic [7:0] mb;
    rst_n = 1'b0;
    data = 8'h03;
    slave_num = 1'b0;
    miso3 = 1'b1;
    s_pre[0] = 8'h00;
    s_pre[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs1", cs1, 1);
    chk("rst_cs2", cs2, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cw", can_write, 0);
    chk("rst_rx", sdom, 0);
    chk("rst_rx3", sdom3, 0);

    // first frame after release, then a data+=3 producer stream
    rst_n = 1'b1;
    @(negedge clk);
    chk("cw_first", can_write, 1);
    run_frame(8'h03, 1'b0, 8'hA5, 1'b0);
    run_frame(8'h00, 1'b0, 8'h11, 1'b0);
    run_frame(8'h03, 1'b0, 8'h22, 1'b0);
    run_frame(8'h06, 1'b0, 8'h33, 1'b0);
    run_frame(8'h09, 1'b0, 8'h44, 1'b0);

    // slave 1, then a mid-frame slave_num/data change
    run_frame(8'hFF, 1'b1, 8'h3C, 1'b0);
    run_frame(8'h5A, 1'b0, 8'hC3, 1'b1);
    run_frame(8'hA5, 1'b1, 8'h96, 1'b0);

    // reset in the 4th sclk-high phase
    data = 8'h77;
    slave_num = 1'b0;
    s_pre[0] = 8'h81;
    sb.push_back('{tx: 8'h77, sel: 1'b0, rx: 8'h81});
    n = 0; r = 0; p = sclk;
    while (r < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (sclk && !p) r++;
      p = sclk;
    end
    chk("reach_edge4", r, 4);
    rst_n = 1'b0;
    #1;
    chk("abort_cs1", cs1, 1);
    chk("abort_cs2", cs2, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_rx", sdom, 0);
    chk("abort_cw", can_write, 0);
    void'(sb.pop_front());
    repeat (3) @(negedge clk);
    chk("held_cw", can_write, 0);
    rst_n = 1'b1;
    wait_cw();
    run_frame(8'h6B, 1'b0, 8'hD2, 1'b0);

    // SCLK_HALF=3 instance
    n = 0;
    while (!can_write3 && n < 120) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cw3", can_write3, 1);
    data = 8'h81;
    n = 0; r = 0; t1 = 0; t2 = 0; seen = 0; done = 0; mb = 8'h00; p = sclk3;
    while (!done && n < 120) begin
      @(negedge clk);
      n++;
      if (sclk3 && !p) begin
        r++;
        mb = {mb[6:0], mosi3};
        if (r == 1) t1 = n;
        if (r == 2) t2 = n;
      end
      p = sclk3;
      if (!cs2_3) seen = 0;
      if (!cs1_3) seen = 1;
      else if (seen) done = 1;
    end
    chk("f3_done", done, 1);
    chk("f3_len", n + 1, 53);
    chk("f3_period", t2 - t1, 6);
    chk("f3_rises", r, 8);
    chk("f3_mosi", mb, 8'h81);
    chk("f3_rx", sdom3, 8'hFF);
    @(negedge clk);
    chk("f3_cw", can_write3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
